uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- Serial-to-parallel receive side of the team's 8N1 UART.
- Oversamples the FTDI RX line using a clock from the baud rate generator running at OVERSAMPLE × baud.
- Recovers one byte per frame and presents it to the receive buffer with a single-cycle valid strobe.
- Flags framing errors and false start bits.

Parameters:
- OVERSAMPLE, 16, clk cycles per bit period; must be an even integer ≥ 4.

Ports:
- clk  input  1  oversample clock from baud rate generator
- rst  input  1  asynchronous, active-low reset from system
- serialInput  input  1  raw RX line from FTDI UART; idle high; asynchronous to clk
- receivedByte  output  8  last correctly framed byte, to buffer
- valid  output  1  one-cycle pulse: receivedByte just updated
- frameError  output  1  one-cycle pulse: stop bit sampled low
- parityError  output  1  one-cycle pulse: parity mismatch (optional feature only)

Behaviour:
- Reset: rst is asynchronous and active-low; clk is the only clock. While rst=0 the following hold:
  - state = IDLE.
  - Sync flops = 1.
  - Counters = 0.
  - receivedByte = 8'h00.
  - valid, frameError and parityError = 0.
- Reset mid-frame aborts the frame silently. No pulse is generated.
- Input sync: serialInput passes through 2 flops. All decisions use the synchronized bit (rxSync).
- Counters:
  - tickCounter, width $clog2(OVERSAMPLE), counts clk cycles within a bit.
  - bitCounter, 3 bits, indexes data bits LSB first.
- State IDLE:
  - Leave when rxSync=0. Go to START and clear tickCounter.
- State START:
  - tickCounter increments each cycle.
  - At tickCounter = OVERSAMPLE/2-1 (mid start bit), resample:
    - rxSync=1: false start. Return to IDLE with no pulse.
    - rxSync=0: go to DATA, clear tickCounter and bitCounter.
- State DATA:
  - When tickCounter reaches OVERSAMPLE-1 (mid bit), sample rxSync into shift[bitCounter], clear tickCounter, increment bitCounter.
  - After the sample at bitCounter=7, go to STOP.
- State STOP:
  - At mid stop bit (tickCounter = OVERSAMPLE-1), sample rxSync:
    - 1: receivedByte <= shift and valid=1 for exactly the next cycle. Go to IDLE.
    - 0: frameError=1 for one cycle. receivedByte is unchanged. Go to BREAK.
- State BREAK:
  - Wait for rxSync=1, then go to IDLE.
  - A held-low line (break) produces exactly one frameError and no further frames.
- Timing:
  - Returning to IDLE at mid stop bit allows back-to-back frames with one stop bit.
  - The next start edge is detected normally.
- Latency: let E = first clk edge sampling serialInput=0.
  - valid rises at edge E + 2 + OVERSAMPLE/2 + 9×OVERSAMPLE, i.e. E+154 at OVERSAMPLE=16.
  - Optional parity adds OVERSAMPLE.
- valid, frameError and parityError are never asserted simultaneously.
- receivedByte holds its value between frames.
- Glitches shorter than OVERSAMPLE/2 cycles on an idle line are rejected by the mid-start check.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state sits between DATA and STOP and samples one extra bit at its midpoint.
  - Mismatch against even parity of the data bits gives parityError=1 for one cycle at stop-bit sample time, instead of valid. receivedByte is not updated.
  - If the stop bit is also 0, only frameError is raised.
- Undefined:
  - 8N1 as above. PARITY state absent. parityError tied to 0.

Test Plan:
- Reset released, line idle high for 100 cycles → valid, frameError and parityError stay 0; receivedByte=8'h00.
- Frame 8'hA5 at 16 clk/bit, serialInput low first at edge E → valid pulses for exactly 1 cycle at E+154; receivedByte=8'hA5.
- Back-to-back frames 8'h00 then 8'hFF, each with a single stop bit → two valid pulses, 160 cycles apart, with bytes 8'h00 and 8'hFF.
- Low glitch of 5 cycles on an idle line → no pulse, returns to IDLE; a following 8'h3C frame is received correctly.
- Frame 8'h55 with stop bit 0, then line held low for 40 bit times → one frameError pulse, receivedByte unchanged. After the line returns high, frame 8'h12 gives valid with 8'h12.
- Assert rst low at mid-DATA of 8'hC3 → all outputs cleared immediately. After release, a complete 8'h81 frame gives valid with 8'h81.
- With UART_RX_PARITY_EN: frame 8'h07 with parity bit 0 → parityError pulse, no valid. With parity bit 1 → valid with 8'h07.

Source files
------------

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receive path, oversampled; define UART_RX_PARITY_EN for 8E1 with parity check
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serialInput,
    output logic [7:0] receivedByte,
    output logic       valid,
    output logic       frameError,
    output logic       parityError
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t        state, state_next;
    logic          sync_meta, rx_sync;
    logic [TW-1:0] tick, tick_next;
    logic [2:0]    bit_cnt, bit_next;
    logic [7:0]    shift, shift_next;
    logic [7:0]    byte_next;
    logic          valid_next, frame_next;
`ifdef UART_RX_PARITY_EN
    logic          par_bit, par_bit_next;
    logic          parity_next;
`endif

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= 1'b1;
            rx_sync   <= 1'b1;
        end else begin
            sync_meta <= serialInput;
            rx_sync   <= sync_meta;
        end
    end

    // State, counters, data and registered output pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            tick         <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            receivedByte <= 8'h00;
            valid        <= 1'b0;
            frameError   <= 1'b0;
        end else begin
            state        <= state_next;
            tick         <= tick_next;
            bit_cnt      <= bit_next;
            shift        <= shift_next;
            receivedByte <= byte_next;
            valid        <= valid_next;
            frameError   <= frame_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Received parity bit and parity error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bit     <= 1'b0;
            parityError <= 1'b0;
        end else begin
            par_bit     <= par_bit_next;
            parityError <= parity_next;
        end
    end
`else
    assign parityError = 1'b0;
`endif

    // Frame sequencing: mid-start check, mid-bit sampling, stop-bit verdict
    always_comb begin
        state_next = state;
        tick_next  = tick + TW'(1);
        bit_next   = bit_cnt;
        shift_next = shift;
        byte_next  = receivedByte;
        valid_next = 1'b0;
        frame_next = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_next = par_bit;
        parity_next  = 1'b0;
`endif
        case (state)
            IDLE: begin
                tick_next = '0;
                if (!rx_sync) state_next = START;
            end
            START: begin
                if (tick == TICK_MID) begin
                    tick_next  = '0;
                    bit_next   = '0;
                    // A line back high by mid start bit was a glitch
                    state_next = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick == TICK_LAST) begin
                    tick_next           = '0;
                    shift_next[bit_cnt] = rx_sync;
                    bit_next            = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick == TICK_LAST) begin
                    tick_next    = '0;
                    par_bit_next = rx_sync;
                    state_next   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick == TICK_LAST) begin
                    tick_next = '0;
                    if (rx_sync) begin
                        // Leaving at mid stop bit lets the next start edge through
                        state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bit != ^shift) begin
                            parity_next = 1'b1;
                        end else begin
                            byte_next  = shift;
                            valid_next = 1'b1;
                        end
`else
                        byte_next  = shift;
                        valid_next = 1'b1;
`endif
                    end else begin
                        frame_next = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                // Held-low line: one frame error only, wait for idle
                tick_next = '0;
                if (rx_sync) state_next = IDLE;
            end
            default: begin
                tick_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

endmodule
